my_sub_module: RTL and testbench

- Inverse of the team's registered adder. It takes a (W+1)-bit sum `c` and one W-bit operand `b`, and recovers the other operand `a = c - b`.
- Flags results that do not fit in W bits.
- Sits downstream of the adder path, for checking and decomposition.
- Valid/ready on both sides, with a 2-entry output buffer for full throughput under backpressure.

---
 rtl/my_sub_module.sv | 120 ++++++++++++
 tb/tb_my_sub_module.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/my_sub_module.sv
// Registered subtractor: recovers a = c - b from a (W+1)-bit sum and a W-bit operand.
// Optional pop/error statistics counters are built in when MY_SUB_STATS_EN is defined.

package my_package;
    localparam int my_width = 8;
endpackage

module my_sub_module #(
    parameter int W = my_package::my_width
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W:0]   c,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] a,
    output logic         err
`ifdef MY_SUB_STATS_EN
    ,
    output logic [15:0]  xfer_count,
    output logic [15:0]  err_count
`endif
);

    logic [W+1:0] diff;
    logic         underflow;
    logic         overflow;
    logic         result_err;

    logic [W-1:0] entry_a_reg   [2];
    logic         entry_err_reg [2];
    logic         rd_ptr_reg;
    logic         wr_ptr_reg;
    logic [1:0]   count_reg;
    logic [1:0]   count_next;
    logic         in_ready_reg;

    logic         accept;
    logic         pop;

    // Two guard bits: bit W+1 is the borrow, bit W catches results too wide for W bits.
    assign diff       = {1'b0, c} - {2'b00, b};
    assign underflow  = diff[W+1];
    assign overflow   = !underflow && diff[W];
    assign result_err = underflow | overflow;

    assign accept = in_valid && in_ready_reg;
    assign pop    = out_valid && out_ready;

    always_comb begin
        count_next = count_reg;
        case ({accept, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            count_reg    <= 2'd0;
            in_ready_reg <= 1'b0;
        end else begin
            count_reg    <= count_next;
            // Ready comes from the next occupancy, so it never depends on out_ready combinationally.
            in_ready_reg <= (count_next != 2'd2);
            if (accept) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                entry_a_reg[i]   <= '0;
                entry_err_reg[i] <= 1'b0;
            end
        end else if (accept) begin
            entry_a_reg[wr_ptr_reg]   <= diff[W-1:0];
            entry_err_reg[wr_ptr_reg] <= result_err;
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = (count_reg != 2'd0);
    assign a         = entry_a_reg[rd_ptr_reg];
    assign err       = entry_err_reg[rd_ptr_reg];

`ifdef MY_SUB_STATS_EN
    logic [15:0] xfer_count_reg;
    logic [15:0] err_count_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            xfer_count_reg <= 16'd0;
            err_count_reg  <= 16'd0;
        end else if (pop) begin
            if (xfer_count_reg != 16'hFFFF) begin
                xfer_count_reg <= xfer_count_reg + 16'd1;
            end
            if (err && (err_count_reg != 16'hFFFF)) begin
                err_count_reg <= err_count_reg + 16'd1;
            end
        end
    end

    assign xfer_count = xfer_count_reg;
    assign err_count  = err_count_reg;
`endif

endmodule

// File: tb/tb_my_sub_module.sv
// Directed bench for my_sub_module at W=8: reset, arithmetic corners, backpressure,
// streaming throughput and mid-run reset (plus counters when MY_SUB_STATS_EN is defined).

module tb_my_sub_module;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   c;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic         err;
`ifdef MY_SUB_STATS_EN
    logic [15:0]  xfer_count;
    logic [15:0]  err_count;
`endif

    int n_cmp = 0;
    int n_err = 0;

    my_sub_module #(.W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .c         (c),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a         (a),
        .err       (err)
`ifdef MY_SUB_STATS_EN
        ,
        .xfer_count(xfer_count),
        .err_count (err_count)
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end else begin
            $display("ok   %s value=%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one transaction and return just after the edge that accepts it.
    task automatic send(input logic [W:0] cc, input logic [W-1:0] bb);
        int n = 0;
        in_valid = 1'b1;
        c = cc;
        b = bb;
        while (!in_ready && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) check("send_timeout", 32'd0, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    logic [W:0]   bp_c [4] = '{9'h050, 9'h1FF, 9'h0A0, 9'h077};
    logic [W-1:0] bp_b [4] = '{8'h10,  8'hFF,  8'hA1,  8'h33};

    initial begin
        logic [8:0] exp_q [$];
        int acc;
        int idx;
        int outs;
        int stalls;
        int stale;
        int ci;
        int bi;
        int df;
        logic [8:0] e;

        reset     = 1'b0;
        in_valid  = 1'b1;
        c         = 9'h12C;
        b         = 8'h2C;
        out_ready = 1'b1;

        // Reset held with a pending source transaction.
        repeat (3) @(posedge clock);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd0);
        check("rst_a",         32'(a),         32'd0);
        check("rst_err",       32'(err),       32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("rst_release_in_ready", 32'(in_ready), 32'd1);
        check("rst_release_out_valid", 32'(out_valid), 32'd0);

        // Basic: 300-44=256 overflows; 255-1=254 fits.
        send(9'h12C, 8'h2C);
        check("basic_ovf", {23'd0, err, a}, {23'd0, 1'b1, 8'h00});
        send(9'h0FF, 8'h01);
        check("basic_ok", {23'd0, err, a}, {23'd0, 1'b0, 8'hFE});

        // Underflow: 3-5 wraps to FE; equal operands give zero.
        send(9'h003, 8'h05);
        check("udf", {23'd0, err, a}, {23'd0, 1'b1, 8'hFE});
        send(9'h005, 8'h05);
        check("equal", {23'd0, err, a}, {23'd0, 1'b0, 8'h00});
        tick();
        check("drained", 32'(out_valid), 32'd0);

        // Backpressure: only two entries fit while the sink stalls.
        out_ready = 1'b0;
        acc = 0;
        idx = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 6; k++) begin
            c = bp_c[idx];
            b = bp_b[idx];
            if (in_ready) begin
                acc++;
                tick();
                idx++;
            end else begin
                tick();
            end
        end
        c = bp_c[idx];
        b = bp_b[idx];
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_head0", {23'd0, err, a}, {23'd0, 1'b0, 8'h40});
        out_ready = 1'b1;
        tick();
        check("bp_head1", {23'd0, err, a}, {23'd0, 1'b1, 8'h00});
        check("bp_ready_back", 32'(in_ready), 32'd1);
        tick();
        c = bp_c[3];
        b = bp_b[3];
        check("bp_head2", {23'd0, err, a}, {23'd0, 1'b1, 8'hFF});
        tick();
        in_valid = 1'b0;
        check("bp_head3", {23'd0, err, a}, {23'd0, 1'b0, 8'h44});
        tick();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Throughput: 100 back-to-back transactions, sink always ready.
        outs = 0;
        stalls = 0;
        for (int k = 0; k <= 101; k++) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("tp_extra_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("tp_out%0d", outs), {23'd0, err, a}, {23'd0, e});
                end
                outs++;
            end
            if (k < 100) begin
                ci = (k * 37 + 5) % 512;
                bi = (k * 53 + 11) % 256;
                df = ci - bi;
                e[8]   = (df < 0) || (df > 255);
                e[7:0] = 8'((df + 512) % 256);
                exp_q.push_back(e);
                in_valid = 1'b1;
                c = 9'(ci);
                b = 8'(bi);
                if (!in_ready) stalls++;
            end else begin
                in_valid = 1'b0;
            end
            tick();
        end
        check("tp_outputs", 32'(outs), 32'd100);
        check("tp_stalls", 32'(stalls), 32'd0);

        // Mid-operation reset with a full buffer.
        out_ready = 1'b0;
        send(9'h010, 8'h20);
        send(9'h030, 8'h05);
        check("mr_full_valid", 32'(out_valid), 32'd1);
        check("mr_full_ready", 32'(in_ready), 32'd0);
        reset = 1'b0;
        #1;
        check("mr_async_valid", 32'(out_valid), 32'd0);
        tick();
        reset = 1'b1;
        out_ready = 1'b1;
        stale = 0;
        repeat (3) begin
            tick();
            if (out_valid) stale++;
        end
        check("mr_no_stale", 32'(stale), 32'd0);

        // Three errored results after the reset.
        send(9'h001, 8'h02);
        check("mr_err0", {23'd0, err, a}, {23'd0, 1'b1, 8'hFF});
        send(9'h1F0, 8'h10);
        check("mr_err1", {23'd0, err, a}, {23'd0, 1'b1, 8'hE0});
        send(9'h000, 8'hFF);
        check("mr_err2", {23'd0, err, a}, {23'd0, 1'b1, 8'h01});
        tick();
        check("mr_drained", 32'(out_valid), 32'd0);
`ifdef MY_SUB_STATS_EN
        check("stats_xfer", 32'(xfer_count), 32'd3);
        check("stats_err",  32'(err_count),  32'd3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
